// File: rtl/sim_monitor.sv
// Simulation-control peripheral: console channels into a shared byte FIFO,
// exit register, PC-stall watchdog and exception trap with RUN/DRAIN/HALT sequencing.
module sim_monitor #(
    parameter logic [31:0] PUTC_BASE  = 32'h8000001c,
    parameter logic [31:0] EXIT_ADDR  = 32'h8000002c,
    parameter int          NCHAN      = 2,
    parameter int          FIFO_DEPTH = 8,
    parameter int          WDT_LIMIT  = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wvalid,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    output logic        wready,
    output logic        whit,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        exception,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic [1:0]  tx_chan,
    output logic        done,
    output logic [1:0]  status,
    output logic [31:0] exit_code
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int WW = $clog2(WDT_LIMIT + 1);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_t;
    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] data;
    } tx_ent_t;

    state_t           state;
    tx_ent_t          mem [FIFO_DEPTH];
    tx_ent_t          head;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             full, empty, push, pop;
    logic [NCHAN-1:0] chan_match;
    logic             chan_hit, exit_hit;
    logic [1:0]       chan_idx;
    logic [31:0]      pc_q;
    logic [WW-1:0]    wdt_cnt;
    logic             wdt_trip;

    for (genvar n = 0; n < NCHAN; n++) begin : g_dec
        assign chan_match[n] = (waddr == PUTC_BASE + 32'(4 * n));
    end

    always_comb begin
        chan_hit = 1'b0;
        chan_idx = '0;
        for (int n = 0; n < NCHAN; n++) begin
            if (chan_match[n]) begin
                chan_hit = 1'b1;
                chan_idx = 2'(n);
            end
        end
    end

    assign exit_hit = (waddr == EXIT_ADDR);
    assign whit     = chan_hit | exit_hit;
    // Non-console traffic is never back-pressured; late console writes stall forever.
    assign wready   = chan_hit ? (state == S_RUN && !full) : 1'b1;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = wvalid && chan_hit && state == S_RUN && !full;
    assign pop   = !empty && tx_ready;

    assign head     = mem[rd_ptr[AW-1:0]];
    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : head.data;
    assign tx_chan  = empty ? 2'b00 : head.chan;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{chan: chan_idx, data: wdata[7:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            wdt_cnt <= '0;
        end else begin
            pc_q <= pc;
            if (pc != pc_q || stall)          wdt_cnt <= '0;
            else if (wdt_cnt != WW'(WDT_LIMIT)) wdt_cnt <= wdt_cnt + WW'(1);
        end
    end

    assign wdt_trip = (wdt_cnt == WW'(WDT_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RUN;
            status    <= 2'b00;
            exit_code <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    // exception outranks a same-cycle exit write, which outranks timeout
                    if (exception) begin
                        state     <= S_DRAIN;
                        status    <= 2'b11;
                        exit_code <= '0;
                    end else if (wvalid && exit_hit) begin
                        state     <= S_DRAIN;
                        status    <= 2'b01;
                        exit_code <= wdata;
                    end else if (wdt_trip) begin
                        state     <= S_DRAIN;
                        status    <= 2'b10;
                        exit_code <= '0;
                    end
                end
                S_DRAIN: begin
                    if (empty) begin
                        state <= S_HALT;
                        done  <= 1'b1;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_sim_monitor.sv
// Directed bench for sim_monitor: console ordering, FIFO full/wrap, exit drain,
// watchdog, priority and mid-drain reset.
module tb_sim_monitor;
    localparam logic [31:0] PUTC = 32'h8000001c;
    localparam logic [31:0] EXIT = 32'h8000002c;
    localparam int          WDT  = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wvalid = 1'b0;
    logic [31:0] waddr = '0;
    logic [31:0] wdata = '0;
    logic        wready, whit;
    logic [31:0] pc = 32'h1000;
    logic        stall = 1'b0;
    logic        exception = 1'b0;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  tx_data;
    logic [1:0]  tx_chan;
    logic        done;
    logic [1:0]  status;
    logic [31:0] exit_code;

    int n_cmp = 0;
    int n_err = 0;
    bit pc_run = 1'b1;

    sim_monitor #(
        .PUTC_BASE(PUTC), .EXIT_ADDR(EXIT), .NCHAN(2), .FIFO_DEPTH(8), .WDT_LIMIT(WDT)
    ) dut (
        .clk(clk), .reset(reset), .wvalid(wvalid), .waddr(waddr), .wdata(wdata),
        .wready(wready), .whit(whit), .pc(pc), .stall(stall), .exception(exception),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_chan(tx_chan),
        .done(done), .status(status), .exit_code(exit_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pc_run) pc = pc + 32'd4;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_rst_vals(input string tag);
        chk({tag, ".tx_valid"}, tx_valid, 0);
        chk({tag, ".tx_data"}, tx_data, 0);
        chk({tag, ".tx_chan"}, tx_chan, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".status"}, status, 0);
        chk({tag, ".exit_code"}, exit_code, 0);
    endtask

    initial begin
        tick();
        do_reset();
        chk_rst_vals("rst");

        // decode
        waddr = 32'h1000;  #1; chk("dec.miss.whit", whit, 0); chk("dec.miss.wready", wready, 1);
        waddr = PUTC + 8;  #1; chk("dec.ch2.whit", whit, 0);
        waddr = EXIT;      #1; chk("dec.exit.whit", whit, 1);

        // console ordering
        tx_ready = 1'b1;
        wvalid = 1'b1; waddr = PUTC; wdata = 32'h48; #1;
        chk("ord.whit", whit, 1); chk("ord.wready", wready, 1);
        tick();
        chk("ord.H.valid", tx_valid, 1); chk("ord.H.data", tx_data, 8'h48); chk("ord.H.chan", tx_chan, 0);
        wdata = 32'h69; tick();
        chk("ord.i.data", tx_data, 8'h69); chk("ord.i.chan", tx_chan, 0);
        waddr = PUTC + 4; wdata = 32'h58; tick();
        chk("ord.X.data", tx_data, 8'h58); chk("ord.X.chan", tx_chan, 1);
        wvalid = 1'b0; tick();
        chk("ord.empty", tx_valid, 0);

        // FIFO full, no bypass, pointer wrap
        tx_ready = 1'b0; wvalid = 1'b1; waddr = PUTC;
        for (int i = 0; i < 8; i++) begin
            wdata = 32'h10 + 32'(i); #1;
            chk("full.fill.wready", wready, 1);
            tick();
        end
        wdata = 32'h18; #1;
        chk("full.9th.wready", wready, 0);
        tick();
        chk("full.9th.still", wready, 0);
        tx_ready = 1'b1; #1;
        chk("full.nobypass", wready, 0);
        tick();
        tx_ready = 1'b0; #1;
        chk("full.afterpop.wready", wready, 1);
        tick();
        wvalid = 1'b0; tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("full.drain.valid", tx_valid, 1);
            chk("full.drain.data", tx_data, 32'h10 + 32'(i));
            tick();
        end
        chk("full.drain.empty", tx_valid, 0);
        tx_ready = 1'b0;

        // watchdog with periodic stall: never trips
        pc_run = 1'b0;
        for (int i = 0; i < 300; i++) begin
            stall = (i % 50 == 0);
            tick();
        end
        stall = 1'b0;
        chk("wdt.stall.status", status, 0);

        // watchdog trip on constant PC
        pc = 32'h2000;
        for (int i = 0; i <= WDT; i++) tick();
        chk("wdt.pre.status", status, 0);
        tick();
        chk("wdt.trip.status", status, 2'b10);
        chk("wdt.trip.code", exit_code, 0);
        chk("wdt.trip.done0", done, 0);
        tick();
        chk("wdt.done", done, 1);
        pc_run = 1'b1;
        do_reset();
        chk("wdt.rst.status", status, 0);

        // exit drain
        wvalid = 1'b1; waddr = PUTC;
        wdata = 32'hA1; tick();
        wdata = 32'hA2; tick();
        waddr = PUTC + 4; wdata = 32'hA3; tick();
        waddr = EXIT; wdata = 32'h2a; #1;
        chk("exit.wready", wready, 1);
        tick();
        chk("exit.status", status, 2'b01);
        chk("exit.code", exit_code, 32'h2a);
        chk("exit.done0", done, 0);
        waddr = PUTC; wdata = 32'hEE; #1;
        chk("exit.late.wready", wready, 0);
        tick();
        waddr = EXIT; wdata = 32'h55; #1;
        chk("exit.late.exit.wready", wready, 1);
        tick();
        chk("exit.late.code", exit_code, 32'h2a);
        wvalid = 1'b0; tx_ready = 1'b1;
        chk("exit.b1", tx_data, 8'hA1); tick();
        chk("exit.b2", tx_data, 8'hA2); tick();
        chk("exit.b3", tx_data, 8'hA3); chk("exit.b3.chan", tx_chan, 1); tick();
        chk("exit.nolate", tx_valid, 0);
        chk("exit.done.wait", done, 0);
        tick();
        chk("exit.done", done, 1);
        chk("exit.status.hold", status, 2'b01);
        tx_ready = 1'b0;
        do_reset();

        // exception beats same-cycle exit write
        wvalid = 1'b1; waddr = EXIT; wdata = 32'h77; exception = 1'b1;
        tick();
        wvalid = 1'b0; exception = 1'b0;
        chk("prio.status", status, 2'b11);
        chk("prio.code", exit_code, 0);
        chk("prio.done0", done, 0);
        tick();
        chk("prio.done", done, 1);
        do_reset();

        // reset during DRAIN with bytes queued
        wvalid = 1'b1; waddr = PUTC;
        wdata = 32'h31; tick();
        wdata = 32'h32; tick();
        wvalid = 1'b0; exception = 1'b1; tick();
        exception = 1'b0;
        chk("rd.status", status, 2'b11);
        chk("rd.valid", tx_valid, 1);
        do_reset();
        chk_rst_vals("rd.rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
